// File: rtl/div_pkg.sv
// Shared constants, state encoding and a width helper for the sequential restoring divider.
package div_pkg;

    localparam int DIV_W = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bundle between the controller and the divider.
interface seq_restoring_divider_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/ripple_subtractor.sv
// N-bit a - b built from a chain of full adders fed with ~b and a carry-in of one.
module ripple_subtractor #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N:0]   carry_s;
    logic [N-1:0] b_inv_s;

    assign carry_s[0] = 1'b1;
    assign b_inv_s    = ~b;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]        = a[i] ^ b_inv_s[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b_inv_s[i]) | (carry_s[i] & (a[i] ^ b_inv_s[i]));
    end

    // A final carry of one means a >= b.
    assign no_borrow = carry_s[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one shift-subtract step per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor jumps straight to DONE.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    seq_restoring_divider_if.slave  bus
);

    localparam int                CNT_W     = clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [WIDTH:0]    r_r;
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  d_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              dbz_r;
    logic [WIDTH-1:0]  quotient_r;
    logic [WIDTH-1:0]  remainder_r;

    logic              accept_s;
    logic              zero_fast_s;
    logic              last_step_s;
    logic [WIDTH:0]    s_s;
    logic [WIDTH:0]    diff_s;
    logic [WIDTH:0]    r_step_s;
    logic [WIDTH-1:0]  q_step_s;
    logic              no_borrow_s;
    logic              unused_r_top_s;

    assign s_s = {r_r[WIDTH-1:0], q_r[WIDTH-1]};

    ripple_subtractor #(.N(WIDTH + 1)) u_sub (
        .a         (s_s),
        .b         ({1'b0, d_r}),
        .diff      (diff_s),
        .no_borrow (no_borrow_s)
    );

    assign r_step_s = no_borrow_s ? diff_s : s_s;
    assign q_step_s = {q_r[WIDTH-2:0], no_borrow_s};

    // The partial remainder never exceeds WIDTH bits, so its top bit is only carried along.
    assign unused_r_top_s = r_r[WIDTH];

    assign accept_s    = bus.start && (state_r != ST_RUN);
    assign last_step_s = (state_r == ST_RUN) && (cnt_r == LAST_STEP);

`ifdef DIV_ZERO_FAST_EN
    assign zero_fast_s = (bus.divisor == '0);
`else
    assign zero_fast_s = 1'b0;
`endif

    // Next-state decode for IDLE/RUN/DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_next_s = zero_fast_s ? ST_DONE : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_STEP) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, shift-subtract iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            cnt_r       <= '0;
            dbz_r       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else if (accept_s) begin
            q_r   <= bus.dividend;
            r_r   <= '0;
            d_r   <= bus.divisor;
            cnt_r <= '0;
            dbz_r <= 1'b0;
            if (zero_fast_s) begin
                quotient_r  <= '1;
                remainder_r <= bus.dividend;
                dbz_r       <= 1'b1;
            end
        end else if (state_r == ST_RUN) begin
            q_r   <= q_step_s;
            r_r   <= r_step_s;
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (last_step_s) begin
                quotient_r  <= q_step_s;
                remainder_r <= r_step_s[WIDTH-1:0];
                dbz_r       <= (d_r == '0);
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops them on done.
module tb_seq_restoring_divider;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int q;
        int r;
        int z;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_restoring_divider_if #(.WIDTH(W)) bus ();

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int d);
        exp_t e;
        if (d == 0) begin
            e.q = MASK;
            e.r = a;
            e.z = 1;
        end else begin
            e.q = a / d;
            e.r = a % d;
            e.z = 0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", int'(bus.quotient), e.q);
                check("remainder", int'(bus.remainder), e.r);
                check("div_by_zero", int'(bus.div_by_zero), e.z);
            end
        end
    end

    // Issue one op at the current negedge and wait for its done; optional ignored start mid-RUN.
    task automatic run_op(input int a, input int d, input int glitch);
        int cyc;
        int busy_cyc;
        int exp_lat;
        int exp_busy;
        exp_lat  = (d == 0 && FAST) ? 1 : W + 1;
        exp_busy = (d == 0 && FAST) ? 0 : W;
        bus.start    = 1'b1;
        bus.dividend = W'(a);
        bus.divisor  = W'(d);
        sb.push_back(model(a, d));
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        busy_cyc = 0;
        while (!bus.done && cyc < 4 * W) begin
            if (bus.busy) busy_cyc++;
            if (cyc == glitch && exp_lat > glitch + 1) begin
                bus.start    = 1'b1;
                bus.dividend = W'(~a);
                bus.divisor  = W'(d + 1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("latency", cyc, exp_lat);
        check("busy_cycles", busy_cyc, exp_busy);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        int d;
        exp_t last;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_quotient", int'(bus.quotient), 0);
        check("rst_remainder", int'(bus.remainder), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed operands, issued back-to-back in each DONE cycle.
        run_op(100, 7, 0);
        run_op(255, 1, 0);
        run_op(5, 9, 0);
        run_op(0, 3, 0);
        run_op(37, 0, 0);
        run_op(200, 13, 3);
        run_op(77, 5, 0);
        @(negedge clk);
        @(negedge clk);
        check("held_quotient", int'(bus.quotient), 15);
        check("held_remainder", int'(bus.remainder), 2);
        check("idle_busy", int'(bus.busy), 0);

        // Abort a RUN with reset partway through.
        bus.start = 1'b1;
        bus.dividend = W'(200);
        bus.divisor = W'(3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_quotient", int'(bus.quotient), 0);
        check("abort_remainder", int'(bus.remainder), 0);
        check("abort_dbz", int'(bus.div_by_zero), 0);
        repeat (12) @(negedge clk);
        run_op(200, 3, 0);

        // Start and reset together: reset wins.
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = W'(50);
        bus.divisor = W'(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", int'(bus.busy), 0);
        check("rst_start_quotient", int'(bus.quotient), 0);
        repeat (12) @(negedge clk);
        check("rst_start_idle", int'(bus.busy), 0);

        // Randomized ops with occasional idle gaps, zero divisors and ignored mid-RUN starts.
        for (int i = 0; i < 2500; i++) begin
            a = int'($urandom) & MASK;
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, MASK));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            run_op(a, d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 6)) : 0);
        end
        last = model(a, d);
        repeat (4) @(negedge clk);
        check("final_quotient", int'(bus.quotient), last.q);
        check("final_remainder", int'(bus.remainder), last.r);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
